// File: rtl/tomasulo_pkg.sv
// Shared sizes and types for the Tomasulo register-status logic.
package tomasulo_pkg;
  localparam int NUM_REGS = 32;
  localparam int TAG_W    = 4;
  localparam int XLEN     = 32;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [4:0]       reg_idx_t;

  // Tag 0 means "value lives in the register file".
  localparam tag_t TAG_NONE = '0;
endpackage

// File: rtl/qi_lookup.sv
// Per-source operand lookup: reports whether the source waits on a
// producer, which tag, or whether that producer broadcasts right now.
module qi_lookup
  import tomasulo_pkg::*;
(
  input  tag_t i_qi,
  input  logic i_cdb_valid,
  input  tag_t i_cdb_tag,
  output logic o_busy,
  output tag_t o_tag,
  output logic o_hit
);
  logic w_has_prod;

  // A CDB hit turns a waiting operand into a bypassed one this cycle.
  always_comb begin
    w_has_prod = (i_qi != TAG_NONE);
    o_hit      = i_cdb_valid && w_has_prod && (i_qi == i_cdb_tag);
    o_busy     = w_has_prod && !o_hit;
    o_tag      = o_busy ? i_qi : TAG_NONE;
  end
endmodule

// File: rtl/register_status_table.sv
// Register-status (Qi) table: renames destinations at issue, snoops the
// CDB and drives the register-file write port with the committed result.
module register_status_table
  import tomasulo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  reg_idx_t         issue_rs1,
  input  reg_idx_t         issue_rs2,
  input  reg_idx_t         issue_rd,
  input  logic             issue_rd_en,
  input  tag_t             issue_tag,
  output logic             rs1_busy,
  output tag_t             rs1_tag,
  output logic             rs1_cdb_hit,
  output logic             rs2_busy,
  output tag_t             rs2_tag,
  output logic             rs2_cdb_hit,
  input  logic             cdb_valid,
  input  tag_t             cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  input  logic             flush,
  output logic             rf_we,
  output reg_idx_t         rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [5:0]       busy_count
);
  tag_t [NUM_REGS-1:0] r_qi;
  tag_t [NUM_REGS-1:0] w_qi_nxt;
  logic [NUM_REGS-1:0] w_match;
  reg_idx_t            w_wb_idx;
  logic                w_wb_en;
  logic [5:0]          w_busy_cnt;

  // Lookups see the pre-update table so rs==rd reads the old producer.
  qi_lookup u_rs1 (
    .i_qi        (r_qi[issue_rs1]),
    .i_cdb_valid (cdb_valid),
    .i_cdb_tag   (cdb_tag),
    .o_busy      (rs1_busy),
    .o_tag       (rs1_tag),
    .o_hit       (rs1_cdb_hit)
  );

  qi_lookup u_rs2 (
    .i_qi        (r_qi[issue_rs2]),
    .i_cdb_valid (cdb_valid),
    .i_cdb_tag   (cdb_tag),
    .o_busy      (rs2_busy),
    .o_tag       (rs2_tag),
    .o_hit       (rs2_cdb_hit)
  );

  // Entries waiting on the broadcasting tag; x0 never renames.
  always_comb begin
    w_match = '0;
    for (int i = 1; i < NUM_REGS; i++)
      w_match[i] = cdb_valid && (cdb_tag != TAG_NONE) && (r_qi[i] == cdb_tag);
  end

  // Lowest matching index wins the write port (multi-match is illegal anyway).
  always_comb begin
    w_wb_idx = '0;
    for (int i = NUM_REGS - 1; i >= 1; i--)
      if (w_match[i]) w_wb_idx = reg_idx_t'(i);
    w_wb_en = (|w_match) && !flush;
  end

  // Next table: clear on writeback, issue overrides, flush overrides all.
  always_comb begin
    w_qi_nxt = r_qi;
    for (int i = 1; i < NUM_REGS; i++)
      if (w_match[i]) w_qi_nxt[i] = TAG_NONE;
    if (issue_valid && issue_rd_en && (issue_rd != '0))
      w_qi_nxt[issue_rd] = issue_tag;
    if (flush) w_qi_nxt = '0;
    w_qi_nxt[0] = TAG_NONE;
  end

  // Occupancy of the next-state table.
  always_comb begin
    w_busy_cnt = '0;
    for (int i = 1; i < NUM_REGS; i++)
      if (w_qi_nxt[i] != TAG_NONE) w_busy_cnt = w_busy_cnt + 6'd1;
  end

  // Table, write port and counter registers; waddr/wdata hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qi       <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      busy_count <= '0;
    end else begin
      r_qi       <= w_qi_nxt;
      rf_we      <= w_wb_en;
      busy_count <= w_busy_cnt;
      if (w_wb_en) begin
        rf_waddr <= w_wb_idx;
        rf_wdata <= cdb_data;
      end
    end
  end
endmodule

// File: tb/tb_register_status_table.sv
// Directed bench for register_status_table with a behavioural table model
// checked every negedge plus literal spot checks.
module tb_register_status_table;
  import tomasulo_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            issue_valid = 1'b0;
  reg_idx_t        issue_rs1 = '0;
  reg_idx_t        issue_rs2 = '0;
  reg_idx_t        issue_rd = '0;
  logic            issue_rd_en = 1'b0;
  tag_t            issue_tag = '0;
  logic            rs1_busy, rs1_cdb_hit, rs2_busy, rs2_cdb_hit;
  tag_t            rs1_tag, rs2_tag;
  logic            cdb_valid = 1'b0;
  tag_t            cdb_tag = '0;
  logic [XLEN-1:0] cdb_data = '0;
  logic            flush = 1'b0;
  logic            rf_we;
  reg_idx_t        rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [5:0]      busy_count;

  register_status_table dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_rd_en(issue_rd_en), .issue_tag(issue_tag),
    .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_cdb_hit(rs1_cdb_hit),
    .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_cdb_hit(rs2_cdb_hit),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: which tag each architectural register waits on, plus the
  // last write-port transaction.
  int          m_qi [NUM_REGS];
  logic        m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  int          m_hits, m_low;

  initial begin
    foreach (m_qi[i]) m_qi[i] = 0;
    m_we = 0; m_waddr = 0; m_wdata = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        foreach (m_qi[i]) m_qi[i] = 0;
        m_we = 0; m_waddr = 0; m_wdata = 0;
      end else begin
        m_hits = 0; m_low = 0;
        for (int r = 1; r < NUM_REGS; r++)
          if (cdb_valid && cdb_tag != 0 && m_qi[r] == int'(cdb_tag)) begin
            if (m_hits == 0) m_low = r;
            m_hits++;
          end
        if (m_hits > 1) begin
          n_total++;
          $display("FAIL multi_match: %0d entries hold tag %0d, expected at most 1", m_hits, cdb_tag);
        end
        if (issue_valid && issue_rd_en && issue_tag == 0) begin
          n_total++;
          $display("FAIL issue_tag_zero: got tag 0, expected nonzero");
        end
        m_we = !flush && m_hits > 0;
        if (m_we) begin
          m_waddr = m_low;
          m_wdata = cdb_data;
        end
        if (flush) foreach (m_qi[i]) m_qi[i] = 0;
        else begin
          for (int r = 1; r < NUM_REGS; r++)
            if (cdb_valid && cdb_tag != 0 && m_qi[r] == int'(cdb_tag)) m_qi[r] = 0;
          if (issue_valid && issue_rd_en && issue_rd != 0) m_qi[issue_rd] = issue_tag;
        end
      end
    end
  end

  // Compare every output against the model in the middle of each cycle.
  initial begin
    int q, cnt;
    logic hit, busy;
    forever begin
      @(negedge clk);
      q = m_qi[issue_rs1];
      hit = cdb_valid && q != 0 && q == int'(cdb_tag);
      busy = q != 0 && !hit;
      chk("m_rs1_hit", rs1_cdb_hit, hit);
      chk("m_rs1_busy", rs1_busy, busy);
      chk("m_rs1_tag", rs1_tag, busy ? q : 0);
      q = m_qi[issue_rs2];
      hit = cdb_valid && q != 0 && q == int'(cdb_tag);
      busy = q != 0 && !hit;
      chk("m_rs2_hit", rs2_cdb_hit, hit);
      chk("m_rs2_busy", rs2_busy, busy);
      chk("m_rs2_tag", rs2_tag, busy ? q : 0);
      chk("m_rf_we", rf_we, m_we);
      chk("m_rf_waddr", rf_waddr, m_waddr);
      chk("m_rf_wdata", rf_wdata, m_wdata);
      cnt = 0;
      foreach (m_qi[i]) if (m_qi[i] != 0) cnt++;
      chk("m_busy_count", busy_count, cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd_en = 0; cdb_valid = 0; flush = 0;
  endtask

  task automatic issue(input int rd, input int tg);
    issue_valid = 1; issue_rd_en = 1;
    issue_rd = reg_idx_t'(rd); issue_tag = tag_t'(tg);
  endtask

  task automatic cdb(input int tg, input logic [31:0] d);
    cdb_valid = 1; cdb_tag = tag_t'(tg); cdb_data = d;
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1;
    tick();
    @(negedge clk);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_busy_count", busy_count, 0);
    tick();

    // Rename then broadcast.
    issue(5, 3); tick();
    idle(); issue_rs1 = 5;
    @(negedge clk);
    chk("t1_rs1_busy", rs1_busy, 1);
    chk("t1_rs1_tag", rs1_tag, 3);
    chk("t1_busy_count", busy_count, 1);
    tick();
    cdb(3, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_rs1_hit", rs1_cdb_hit, 1);
    chk("t1_rs1_busy_bypass", rs1_busy, 0);
    tick();
    idle();
    @(negedge clk);
    chk("t1_rf_we", rf_we, 1);
    chk("t1_rf_waddr", rf_waddr, 5);
    chk("t1_rf_wdata", rf_wdata, 32'hDEADBEEF);
    chk("t1_busy_count0", busy_count, 0);
    chk("t1_rs1_clear", rs1_busy, 0);
    tick();

    // WAW: stale result dropped.
    issue(7, 2); tick();
    issue(7, 4); tick();
    idle(); cdb(2, 32'h22); tick();
    idle(); issue_rs1 = 7;
    @(negedge clk);
    chk("waw_rf_we", rf_we, 0);
    chk("waw_rs1_tag", rs1_tag, 4);
    tick();
    cdb(4, 32'h11); tick();
    idle();
    @(negedge clk);
    chk("waw_rf_we2", rf_we, 1);
    chk("waw_rf_waddr", rf_waddr, 7);
    chk("waw_rf_wdata", rf_wdata, 32'h11);
    tick();

    // Writeback and re-issue to the same rd in one cycle.
    issue(9, 6); tick();
    issue(9, 8); cdb(6, 32'h55); tick();
    idle(); issue_rs1 = 9;
    @(negedge clk);
    chk("sim_rf_we", rf_we, 1);
    chk("sim_rf_waddr", rf_waddr, 9);
    chk("sim_rf_wdata", rf_wdata, 32'h55);
    chk("sim_rs1_busy", rs1_busy, 1);
    chk("sim_rs1_tag", rs1_tag, 8);
    tick();

    // x0 is never renamed.
    issue(0, 5); issue_rs1 = 0; tick();
    idle();
    @(negedge clk);
    chk("x0_busy_count", busy_count, 1);
    chk("x0_rs1_busy", rs1_busy, 0);
    tick();
    cdb(5, 32'h77);
    @(negedge clk);
    chk("x0_rs1_hit", rs1_cdb_hit, 0);
    tick();
    idle();
    @(negedge clk);
    chk("x0_rf_we", rf_we, 0);
    tick();

    // Flush, with a writeback already registered in the flush cycle.
    issue(3, 1); tick();
    issue(4, 2); tick();
    issue(11, 9); tick();
    idle(); cdb(9, 32'h99); tick();
    idle(); flush = 1; cdb(1, 32'hAB); issue(10, 7);
    issue_rs1 = 3; issue_rs2 = 4;
    @(negedge clk);
    chk("fl_pending_we", rf_we, 1);
    chk("fl_pending_waddr", rf_waddr, 11);
    chk("fl_pending_wdata", rf_wdata, 32'h99);
    chk("fl_rs1_hit", rs1_cdb_hit, 1);
    tick();
    idle(); issue_rs1 = 10;
    @(negedge clk);
    chk("fl_rf_we", rf_we, 0);
    chk("fl_busy_count", busy_count, 0);
    chk("fl_rs1_busy", rs1_busy, 0);
    chk("fl_rs2_busy", rs2_busy, 0);
    chk("fl_waddr_hold", rf_waddr, 11);
    tick();

    // Asynchronous reset mid-stream discards a pending writeback.
    issue(12, 3); tick();
    issue(13, 5); tick();
    idle(); cdb(5, 32'h5A); issue_rs1 = 12; issue_rs2 = 13; tick();
    idle();
    rst_n = 0;
    #1;
    chk("ar_rf_we", rf_we, 0);
    chk("ar_busy_count", busy_count, 0);
    chk("ar_rs1_busy", rs1_busy, 0);
    chk("ar_rf_waddr", rf_waddr, 0);
    chk("ar_rf_wdata", rf_wdata, 0);
    tick();
    rst_n = 1;
    tick();
    @(negedge clk);
    chk("ar_post_rf_we", rf_we, 0);
    chk("ar_post_rs1_busy", rs1_busy, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
